// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, one multiplier bit per clock.
// Unsigned or two's-complement operands, start/ready/done handshake.
// Optional build macro SEQ_MULTIPLIER_EARLY_EXIT_EN: leaves MUL as soon as
// the remaining multiplier bits are all zero. Results match the default
// build; only the latency is shorter.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               ready,
   output logic               done
);

   // state | meaning
   // IDLE  | ready=1, waiting for start; product holds the last result
   // MUL   | one multiplier bit per edge, accumulating magnitudes
   // SIGN  | apply the result sign, update product, pulse done
   typedef enum logic [1:0] {IDLE, MUL, SIGN} state_t;

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t               state;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CW-1:0]        cnt_q;
   logic                 neg_q;

   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic                 early_exit;

   // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits
   // the unsigned WIDTH-bit magnitude.
   always_comb begin
      mag_a = multiplicand;
      mag_b = multiplier;
      if (signed_mode && multiplicand[WIDTH-1]) mag_a = -multiplicand;
      if (signed_mode && multiplier[WIDTH-1])   mag_b = -multiplier;
   end

   // True when the multiplier left after this edge's shift has no set bits.
   always_comb begin
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
      early_exit = (mplier_q[WIDTH-1:1] == '0);
`else
      early_exit = 1'b0;
`endif
   end

   // Control FSM with datapath registers and registered handshake outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         product  <= '0;
         ready    <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                  mplier_q <= mag_b;
                  neg_q    <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  ready    <= 1'b0;
                  state    <= MUL;
               end
            end
            MUL: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if ((cnt_q == LAST) || early_exit) state <= SIGN;
            end
            SIGN: begin
               product <= neg_q ? -acc_q : acc_q;
               done    <= 1'b1;
               ready   <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8.
module tb_seq_multiplier;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        signed_mode;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic [15:0] product;
   logic        ready;
   logic        done;

   int checks = 0;
   int errors = 0;
   int n;

   seq_multiplier #(.WIDTH(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .ready        (ready),
      .done         (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept-to-done latency for multiplier b.
   function automatic int exp_lat(input logic [7:0] b, input logic sm);
      logic [7:0] mag;
      int k;
      mag = (sm && b[7]) ? -b : b;
      k = 1;
      for (int i = 0; i < 8; i++) if (mag[i]) k = i + 1;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
      return k + 1;
`else
      return 9;
`endif
   endfunction

   // Edges counted from the accept edge (n0 already seen) until done, bounded.
   task automatic wait_done(input int n0, output int nout);
      nout = n0;
      while (!done && nout < 40) begin
         @(posedge clock); #1;
         nout++;
      end
   endtask

   task automatic run_op(input string tag, input logic sm, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] expp);
      int m;
      start = 1'b1; signed_mode = sm; multiplicand = a; multiplier = b;
      @(posedge clock); #1;
      start = 1'b0;
      chk({tag, "_ready_drop"}, ready, 1'b0);
      wait_done(1, m);
      chk({tag, "_latency"}, m - 1, exp_lat(b, sm));
      chk({tag, "_product"}, product, expp);
      chk({tag, "_ready_back"}, ready, 1'b1);
      @(posedge clock); #1;
      chk({tag, "_done_pulse"}, done, 1'b0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; signed_mode = 1'b0;
      multiplicand = '0; multiplier = '0;
      #23 reset = 1'b0;
      @(posedge clock); #1;
      chk("reset_product", product, 16'h0000);
      chk("reset_ready", ready, 1'b1);
      chk("reset_done", done, 1'b0);

      run_op("u200x255", 1'b0, 8'd200, 8'd255, 16'hC738);
      run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
      run_op("s_m3x5", 1'b1, 8'hFD, 8'd5, 16'hFFF1);
      run_op("u80x80", 1'b0, 8'h80, 8'h80, 16'h4000);
      run_op("s5xm1", 1'b1, 8'd5, 8'hFF, 16'hFFFB);
      run_op("s127xm128", 1'b1, 8'd127, 8'h80, 16'hC080);
      run_op("uFFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
      run_op("u0x37", 1'b0, 8'd0, 8'h37, 16'h0000);
      run_op("u5x3", 1'b0, 8'd5, 8'd3, 16'h000F);

      // Back-to-back with start held high across both operations.
      start = 1'b1; signed_mode = 1'b0; multiplicand = 8'd7; multiplier = 8'd6;
      @(posedge clock); #1;
      chk("b2b_first_ready_drop", ready, 1'b0);
      wait_done(1, n);
      chk("b2b_first_latency", n - 1, exp_lat(8'd6, 1'b0));
      chk("b2b_first_product", product, 16'd42);
      multiplicand = 8'd9; multiplier = 8'd9;
      @(posedge clock); #1;
      start = 1'b0;
      chk("b2b_second_accepted", ready, 1'b0);
      wait_done(1, n);
      chk("b2b_done_spacing", n - 1, exp_lat(8'd9, 1'b0));
      chk("b2b_second_product", product, 16'd81);
      @(posedge clock); #1;

      // start pulsed during MUL with different operands must be ignored.
      start = 1'b1; multiplicand = 8'd3; multiplier = 8'd4;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      start = 1'b1; multiplicand = 8'd100; multiplier = 8'd100;
      @(posedge clock); #1;
      start = 1'b0;
      chk("ignore_ready_low", ready, 1'b0);
      chk("ignore_product_held", product, 16'd81);
      wait_done(4, n);
      chk("ignore_latency", n - 1, exp_lat(8'd4, 1'b0));
      chk("ignore_product", product, 16'd12);
      @(posedge clock); #1;
      chk("ignore_no_second_op", ready, 1'b1);

      // Reset asserted in the fourth MUL cycle aborts immediately.
      start = 1'b1; multiplicand = 8'd200; multiplier = 8'hFF;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_product", product, 16'h0000);
      chk("abort_ready", ready, 1'b1);
      chk("abort_done", done, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clock); #1;
         if (done) n++;
      end
      chk("abort_no_done", n, 0);
      chk("abort_idle_ready", ready, 1'b1);

      run_op("after_abort_u7x6", 1'b0, 8'd7, 8'd6, 16'd42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
